// File: rtl/ptp_eth_framer.sv
// Wraps PTP messages arriving on an AXI-Stream byte interface into Ethernet frames:
// a fixed 14-byte header, the payload (zero-padded up to MIN_PAYLOAD, cut at MAX_PAYLOAD).
module ptp_eth_framer #(
    parameter logic [47:0] DST_MAC     = 48'h011B19000000,
    parameter logic [47:0] SRC_MAC     = 48'h020000000001,
    parameter logic [15:0] ETHERTYPE   = 16'h88F7,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  trunc_cnt,
    output logic [2:0]  dbg_state
);

    // Both ports use AXI-Stream rules: a byte moves only on a rising edge where
    // tvalid and tready are both high; a producer holds its byte until it moves.
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DROP} state_t;

    localparam logic [10:0]  MIN_CNT   = 11'(MIN_PAYLOAD);
    localparam logic [10:0]  MAX_CNT   = 11'(MAX_PAYLOAD);
    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};

    state_t      state_q, state_d;
    logic [3:0]  hdr_idx_q, hdr_idx_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  trunc_cnt_q, trunc_cnt_d;
    logic [10:0] cnt_inc;
    logic [7:0]  hdr_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_idx_q   <= 4'd0;
            cnt_q       <= 11'd0;
            frame_cnt_q <= 16'd0;
            trunc_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    // Header byte 0 is the top byte of HDR_BYTES; index 13 selects the low byte.
    always_comb begin
        hdr_byte = 8'(HDR_BYTES >> (8'd104 - {1'b0, hdr_idx_q, 3'b000}));
    end

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        cnt_d         = cnt_q;
        frame_cnt_d   = frame_cnt_q;
        trunc_cnt_d   = trunc_cnt_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        cnt_inc       = cnt_q + 11'd1;

        case (state_q)
            IDLE: begin
                hdr_idx_d = 4'd0;
                cnt_d     = 11'd0;
                if (s_axis_tvalid) state_d = HDR;
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
                if (m_axis_tready) begin
                    if (hdr_idx_q == 4'd13) state_d = PAYLOAD;
                    else hdr_idx_d = hdr_idx_q + 4'd1;
                end
            end
            PAYLOAD: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                // A real upstream tlast wins over the truncation point on the same beat.
                if (s_axis_tlast) m_axis_tlast = s_axis_tvalid && (cnt_inc >= MIN_CNT);
                else              m_axis_tlast = s_axis_tvalid && (cnt_inc == MAX_CNT);
                if (s_axis_tvalid && m_axis_tready) begin
                    cnt_d = cnt_inc;
                    if (s_axis_tlast) begin
                        if (cnt_inc >= MIN_CNT) begin
                            state_d     = IDLE;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end else begin
                            state_d = PAD;
                        end
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d     = DROP;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (trunc_cnt_q != 8'hFF) trunc_cnt_d = trunc_cnt_q + 8'd1;
                    end
                end
            end
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (cnt_inc >= MIN_CNT);
                if (m_axis_tready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ptp_eth_framer.sv
// Bench for ptp_eth_framer: random message bytes, expected frames built from the
// header/pad/truncate rules with plain queue arithmetic.
module tb_ptp_eth_framer;

    localparam logic [47:0] DST  = 48'h011B19000000;
    localparam logic [47:0] SRC  = 48'h020000000001;
    localparam logic [15:0] ET   = 16'h88F7;
    localparam int          MINP = 46;
    localparam int          MAXP = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  trunc_cnt;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;
    int exp_trunc = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] msg[$];

    ptp_eth_framer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .trunc_cnt     (trunc_cnt),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected frame as {tlast, byte}: header, payload (cut at MAXP), zeros up to MINP.
    function automatic void build_expected(input int len);
        logic [111:0] hdr;
        int pay;
        int tot;
        hdr = {DST, SRC, ET};
        pay = (len > MAXP) ? MAXP : len;
        tot = 14 + ((pay < MINP) ? MINP : pay);
        exp_q.delete();
        for (int i = 0; i < tot; i++) begin
            logic [7:0] b;
            if (i < 14)            b = hdr[111 - 8*i -: 8];
            else if (i < 14 + pay) b = msg[i - 14];
            else                   b = 8'h00;
            exp_q.push_back({(i == tot - 1), b});
        end
    endfunction

    // rdy_mode: 0 always ready, 1 toggle, 2 random. abort_at >= 0 stops after that many output bytes.
    task automatic run_frame(input int len, input int rdy_mode, input int gap_pct,
                             input int abort_at, input string name);
        int idx = 0;
        int cyc = 0;
        int pos;
        int pay;
        int bad;
        int first_bad;
        int last_pos;
        bit done = 0;
        bit saw_last = 0;
        bit stalled = 0;
        logic [8:0] held = '0;
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
        build_expected(len);
        got_q.delete();
        pay = (len > MAXP) ? MAXP : len;
        while (!done) begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 2 == 0);
                default: m_tready = ($urandom_range(0, 99) < 70);
            endcase
            if (idx < len && $urandom_range(0, 99) >= gap_pct) begin
                s_tvalid = 1'b1;
                s_tdata  = msg[idx];
                s_tlast  = (idx == len - 1);
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = 8'($urandom);
                s_tlast  = 1'b0;
            end
            #1;
            pos = got_q.size();
            if (stalled && m_tvalid && (pos < 14 || pos >= 14 + pay)) begin
                checks++;
                if ({m_tlast, m_tdata} !== held) begin
                    errors++;
                    $display("FAIL %s hold pos %0d: got %h expected %h", name, pos, {m_tlast, m_tdata}, held);
                end
            end
            stalled = m_tvalid && !m_tready;
            held    = {m_tlast, m_tdata};
            if (s_tvalid && s_tready) idx++;
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                if (m_tlast) saw_last = 1;
            end
            cyc++;
            if (abort_at >= 0 && got_q.size() == abort_at) done = 1;
            else if (saw_last && idx == len) done = 1;
            else if (cyc > 12 * len + 600) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: out %0d of %0d bytes, in %0d of %0d", name,
                         got_q.size(), exp_q.size(), idx, len);
                done = 1;
            end
        end
        if (abort_at >= 0) return;

        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s length: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s data: %0d bad bytes, first at %0d got %h expected %h", name, bad,
                     first_bad, got_q[first_bad], exp_q[first_bad]);
        end
        last_pos = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i][8] && last_pos < 0) last_pos = i;
        checks++;
        if (last_pos != exp_q.size() - 1) begin
            errors++;
            $display("FAIL %s tlast position: got %0d expected %0d", name, last_pos, exp_q.size() - 1);
        end

        exp_frames = (exp_frames + 1) % 65536;
        if (len > MAXP && exp_trunc < 255) exp_trunc++;
        // Next message is offered immediately: the framer must still sit in IDLE one cycle.
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 8'hA5;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle gap: busy %b m_tvalid %b expected 0 0", name, busy, m_tvalid);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, exp_frames);
        end
        checks++;
        if (trunc_cnt !== 8'(exp_trunc)) begin
            errors++;
            $display("FAIL %s trunc_cnt: got %0d expected %0d", name, trunc_cnt, exp_trunc);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready, busy, frame_cnt, trunc_cnt} !== 36'd0) begin
            errors++;
            $display("FAIL %s outputs: m_tvalid %b m_tlast %b m_tdata %h s_tready %b busy %b frame_cnt %0d trunc_cnt %0d expected all 0",
                     name, m_tvalid, m_tlast, m_tdata, s_tready, busy, frame_cnt, trunc_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_ptp_44();
        run_frame(44, 0, 0, -1, "ptp44");
    endtask

    task automatic test_short_pad();
        run_frame(1, 0, 0, -1, "pad1");
        run_frame(45, 0, 0, -1, "len45");
        run_frame(46, 0, 0, -1, "len46");
        run_frame(47, 2, 0, -1, "len47");
    endtask

    task automatic test_no_pad();
        run_frame(100, 0, 0, -1, "len100");
    endtask

    task automatic test_stall();
        run_frame(44, 1, 0, -1, "toggle44");
        run_frame(20, 1, 0, -1, "toggle_pad");
    endtask

    task automatic test_truncate();
        run_frame(1600, 0, 0, -1, "trunc1600");
        run_frame(1500, 0, 0, -1, "exact1500");
        run_frame(1501, 2, 10, -1, "trunc1501");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) run_frame($urandom_range(1, 120), 2, 25, -1, "random");
    endtask

    task automatic test_reset_mid_frame();
        run_frame(44, 0, 0, 20, "mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_frames = 0;
        exp_trunc = 0;
        @(negedge clk);
        rst = 1'b0;
        run_frame(44, 0, 0, -1, "post_reset44");
    endtask

    initial begin
        test_reset();
        test_ptp_44();
        test_short_pad();
        test_no_pad();
        test_stall();
        test_truncate();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
